// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared FSM state type and byte-lane sizing for the IMEM loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam int DEFAULT_DW     = 32;
   localparam int BYTES_PER_WORD = DEFAULT_DW / 8;
   localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   // A one-byte word still needs a 1-bit index register.
   function automatic int byte_idx_width(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_packer.sv
// ============================================================================
// Module   : byte_word_packer
// Brief    : Little-endian byte-to-word assembler with lane index counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_packer
   import imem_loader_pkg::*;
#(
   parameter int DW = DEFAULT_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_accept,
   input  logic [7:0]    i_byte,
   output logic [DW-1:0] o_word,
   output logic          o_word_valid
);

   localparam int c_BPW   = DW / 8;
   localparam int c_IDX_W = byte_idx_width(c_BPW);
   localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_BPW - 1);

   logic [c_IDX_W-1:0] r_idx;
   logic [DW-1:0]      r_word;

   assign o_word       = r_word;
   assign o_word_valid = i_accept && (r_idx == c_LAST);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_idx <= '0;
      end else if (i_accept) begin
         r_idx <= (r_idx == c_LAST) ? '0 : r_idx + c_IDX_W'(1);
      end
   end

   // First accepted byte lands in the least significant lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word <= '0;
      end else if (i_accept) begin
         for (int l = 0; l < c_BPW; l++) begin
            if (r_idx == c_IDX_W'(l)) begin
               r_word[8*l +: 8] <= i_byte;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Streams bytes into instruction RAM, holding the CPU until loaded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int AW             = 10,
   parameter int DW             = DEFAULT_DW,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   num_words,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          error,
   output logic [AW:0]   word_cnt
);

   localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]        c_MAX_WORDS = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]        c_ONE       = {{AW{1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_state_nxt;
   logic [AW:0]        r_num_words;
   logic [AW:0]        r_word_cnt;
   logic [AW:0]        w_cnt_inc;
   logic [c_TMO_W-1:0] r_tmo;
   logic               w_accept;
   logic               w_start_acc;
   logic               w_tmo_hit;
   logic               w_word_valid;
   logic [DW-1:0]      w_word;

   assign byte_ready = (r_state == ST_LOAD);
   assign mem_we     = (r_state == ST_WRITE);
   assign done       = (r_state == ST_DONE);
   assign error      = (r_state == ST_ERROR);
   assign cpu_hold   = (r_state != ST_DONE);
   assign mem_addr   = r_word_cnt[AW-1:0];
   assign mem_wdata  = w_word;
   assign word_cnt   = r_word_cnt;

   assign w_accept  = byte_valid && byte_ready;
   assign w_cnt_inc = r_word_cnt + c_ONE;
   assign w_tmo_hit = (r_tmo == c_TMO_LAST);

   byte_word_packer #(
      .DW (DW)
   ) u_packer (
      .clk          (clk),
      .rst          (reset),
      .i_clr        (w_start_acc),
      .i_accept     (w_accept),
      .i_byte       (byte_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               w_start_acc = 1'b1;
               if (num_words == '0) begin
                  w_state_nxt = ST_DONE;
               end else if (num_words > c_MAX_WORDS) begin
                  w_state_nxt = ST_ERROR;
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (w_word_valid) begin
               w_state_nxt = ST_WRITE;
            end else if (!w_accept && w_tmo_hit) begin
               w_state_nxt = ST_ERROR;
            end
         end
         ST_WRITE: begin
            w_state_nxt = (w_cnt_inc == r_num_words) ? ST_DONE : ST_LOAD;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Idle timer only runs while waiting for bytes; any accepted byte restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_num_words <= '0;
         r_word_cnt  <= '0;
         r_tmo       <= '0;
      end else if (w_start_acc) begin
         r_num_words <= num_words;
         r_word_cnt  <= '0;
         r_tmo       <= '0;
      end else if (r_state == ST_LOAD) begin
         if (w_accept || w_tmo_hit) begin
            r_tmo <= '0;
         end else begin
            r_tmo <= r_tmo + c_TMO_W'(1);
         end
      end else if (r_state == ST_WRITE) begin
         r_word_cnt <= w_cnt_inc;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for the IMEM byte-stream loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   num_words;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [AW:0]   word_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_n     = 0;
   int acc_n    = 0;
   int bad_hs   = 0;
   logic [AW-1:0] wr_addr [0:1199];
   logic [DW-1:0] wr_data [0:1199];

   imem_loader #(
      .AW             (AW),
      .DW             (DW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   // Outputs are stable at the falling edge; inputs also change only there.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we) begin
            if (wr_n < 1200) begin
               wr_addr[wr_n] = mem_addr;
               wr_data[wr_n] = mem_wdata;
            end
            wr_n++;
            if (byte_ready) bad_hs++;
         end
         if (byte_valid && byte_ready) acc_n++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] img_word(input int i);
      logic [7:0] k;
      k = i[7:0];
      return {k ^ 8'hA5, k + 8'h13, ~k, k};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; num_words = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_load(input int n);
      start     = 1'b1;
      num_words = (AW+1)'(n);
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) chk("byte_ready_wait", 64'd0, 64'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int b = 0; b < 4; b++) begin
         send_byte(w[8*b +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Reset state
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_mem_we",     mem_we,     0);
      chk("rst_mem_addr",   mem_addr,   0);
      chk("rst_mem_wdata",  mem_wdata,  0);
      chk("rst_done",       done,       0);
      chk("rst_error",      error,      0);
      chk("rst_word_cnt",   word_cnt,   0);
      chk("rst_cpu_hold",   cpu_hold,   1);

      // Single word: write in the cycle after the 4th accept, done one later
      wr_n = 0;
      start_load(1);
      chk("sw_cpu_hold", cpu_hold, 1);
      send_word(32'h12345678, 0);
      chk("sw_we",    mem_we,    1);
      chk("sw_addr",  mem_addr,  0);
      chk("sw_data",  mem_wdata, 32'h12345678);
      chk("sw_done_early", done, 0);
      @(negedge clk);
      chk("sw_done",     done,     1);
      chk("sw_cpu_hold_rel", cpu_hold, 0);
      chk("sw_we_off",   mem_we,   0);
      chk("sw_writes",   wr_n,     1);
      chk("sw_word_cnt", word_cnt, 1);

      // Handshake hygiene: IDLE, WRITE, DONE never accept; start in LOAD ignored
      do_reset();
      acc_n = 0; wr_n = 0; bad_hs = 0;
      byte_valid = 1'b1; byte_data = 8'hAA;
      repeat (4) @(negedge clk);
      chk("hs_idle_ready", byte_ready, 0);
      chk("hs_idle_acc",   acc_n,      0);
      byte_valid = 1'b0;
      start_load(2);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      start = 1'b1; num_words = (AW+1)'(5);
      @(negedge clk);
      start = 1'b0;
      chk("hs_start_in_load_cnt", word_cnt, 0);
      chk("hs_start_in_load_st",  byte_ready, 1);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      byte_valid = 1'b1; byte_data = 8'h55;
      chk("hs_write_ready", byte_ready, 0);
      chk("hs_write_we",    mem_we,     1);
      send_word(32'hCAFEF00D, 0);
      @(negedge clk);
      byte_valid = 1'b1; byte_data = 8'h77;
      repeat (4) @(negedge clk);
      chk("hs_done",       done,       1);
      chk("hs_done_ready", byte_ready, 0);
      chk("hs_word_cnt",   word_cnt,   2);
      chk("hs_acc",        acc_n,      8);
      chk("hs_bad",        bad_hs,     0);
      chk("hs_writes",     wr_n,       2);
      chk("hs_data0",      wr_data[0], 32'h04030201);
      chk("hs_data1",      wr_data[1], 32'hCAFEF00D);
      byte_valid = 1'b0;

      // 123-word image with random gaps
      wr_n = 0;
      start_load(123);
      for (int i = 0; i < 123; i++) send_word(img_word(i), 5);
      repeat (3) @(negedge clk);
      chk("img_writes",   wr_n,     123);
      chk("img_word_cnt", word_cnt, 123);
      chk("img_done",     done,     1);
      for (int i = 0; i < 123; i++) begin
         chk($sformatf("img_addr%0d", i), wr_addr[i], i);
         chk($sformatf("img_data%0d", i), wr_data[i], img_word(i));
      end

      // Timeout: second word stalls after one byte
      wr_n = 0;
      start_load(2);
      send_word(32'h11223344, 0);
      send_byte(8'h99, 0);
      repeat (15) @(negedge clk);
      chk("to_error_early", error, 0);
      @(negedge clk);
      chk("to_error",    error,    1);
      chk("to_cpu_hold", cpu_hold, 1);
      chk("to_writes",   wr_n,     1);
      chk("to_data",     wr_data[0], 32'h11223344);
      repeat (3) @(negedge clk);
      chk("to_error_sticky", error, 1);

      // Size boundary: 1025 rejected, 1024 fills the whole RAM, 0 done at once
      wr_n = 0;
      start_load(1025);
      repeat (3) @(negedge clk);
      chk("sz1025_error",  error, 1);
      chk("sz1025_writes", wr_n,  0);
      start_load(1024);
      chk("sz1024_error_clr", error, 0);
      for (int i = 0; i < 1024; i++) send_word(img_word(i), 0);
      repeat (3) @(negedge clk);
      chk("sz1024_writes",   wr_n,     1024);
      chk("sz1024_word_cnt", word_cnt, 1024);
      chk("sz1024_done",     done,     1);
      for (int i = 0; i < 1024; i++) begin
         chk($sformatf("sz_addr%0d", i), wr_addr[i], i);
         chk($sformatf("sz_data%0d", i), wr_data[i], img_word(i));
      end
      wr_n = 0;
      start_load(0);
      chk("sz0_done",     done,     1);
      chk("sz0_word_cnt", word_cnt, 0);
      repeat (3) @(negedge clk);
      chk("sz0_writes",   wr_n,     0);

      // Mid-word reset: word 5 partial bytes are dropped
      wr_n = 0;
      start_load(8);
      for (int i = 0; i < 5; i++) send_word(img_word(i + 40), 0);
      send_byte(8'hA1, 0);
      send_byte(8'hA2, 0);
      do_reset();
      repeat (4) @(negedge clk);
      chk("mw_writes_pre", wr_n, 5);
      chk("mw_addr4",      wr_addr[4], 4);
      chk("mw_word_cnt",   word_cnt, 0);
      start_load(1);
      send_word(32'hDEADBEEF, 0);
      repeat (2) @(negedge clk);
      chk("mw_writes",  wr_n,       6);
      chk("mw_addr",    wr_addr[5], 0);
      chk("mw_data",    wr_data[5], 32'hDEADBEEF);
      chk("mw_done",    done,       1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
